// File: rtl/synth_param_decoder.sv
// Byte-stream command decoder that writes oscillator parameter registers.
// Optional trailing XOR checksum byte per frame: define SYNTH_PARAM_CHECKSUM_EN.
//
// state  | meaning
// S_IDLE | waiting for a command byte
// S_DATA | assembling parameter bytes (and checksum byte when enabled)
module synth_param_decoder #(
    parameter int NUM_OSC        = 2,
    parameter int WAVE_W         = 8,
    parameter int FREQ_W         = 24,
    parameter int PHASE_W        = 16,
    parameter int AMP_W          = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [7:0]                 i_data,
    input  logic                       i_data_valid,
    output logic [NUM_OSC*WAVE_W-1:0]  o_osc_wave,
    output logic [NUM_OSC*FREQ_W-1:0]  o_osc_freq,
    output logic [NUM_OSC*PHASE_W-1:0] o_osc_phase,
    output logic [NUM_OSC*AMP_W-1:0]   o_osc_amp,
    output logic [NUM_OSC-1:0]         o_update,
    output logic                       o_busy,
    output logic                       o_cmd_err,
    output logic                       o_timeout
);

    localparam logic [2:0] NB_WAVE  = 3'((WAVE_W + 7) / 8);
    localparam logic [2:0] NB_FREQ  = 3'((FREQ_W + 7) / 8);
    localparam logic [2:0] NB_PHASE = 3'((PHASE_W + 7) / 8);
    localparam logic [2:0] NB_AMP   = 3'((AMP_W + 7) / 8);
    localparam logic [4:0] NUM_OSC_L = 5'(NUM_OSC);
    localparam int TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [0:0] {S_IDLE, S_DATA} state_t;

    state_t                     state_q, state_d;
    logic [3:0]                 osc_q, osc_d;
    logic [2:0]                 id_q, id_d;
    logic [31:0]                buf_q, buf_d;
    logic [2:0]                 cnt_q, cnt_d;
    logic [TO_W-1:0]            to_q, to_d;
    logic [NUM_OSC*WAVE_W-1:0]  wave_q, wave_d;
    logic [NUM_OSC*FREQ_W-1:0]  freq_q, freq_d;
    logic [NUM_OSC*PHASE_W-1:0] phase_q, phase_d;
    logic [NUM_OSC*AMP_W-1:0]   amp_q, amp_d;
    logic [NUM_OSC-1:0]         upd_q, upd_d;
    logic                       err_q, err_d;
    logic                       tmo_q, tmo_d;
    logic                       commit;
    logic [31:0]                commit_val;
    logic [2:0]                 nb;
    logic                       unused_ok;
`ifdef SYNTH_PARAM_CHECKSUM_EN
    logic [7:0]                 chk_q, chk_d;
`endif

    always_comb begin
        state_d = state_q;
        osc_d   = osc_q;
        id_d    = id_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        wave_d  = wave_q;
        freq_d  = freq_q;
        phase_d = phase_q;
        amp_d   = amp_q;
        upd_d   = '0;
        err_d   = 1'b0;
        tmo_d   = 1'b0;
        commit  = 1'b0;
`ifdef SYNTH_PARAM_CHECKSUM_EN
        chk_d      = chk_q;
        commit_val = buf_q;
`else
        commit_val = {buf_q[23:0], i_data};
`endif
        case (id_q)
            3'd1:    nb = NB_WAVE;
            3'd2:    nb = NB_FREQ;
            3'd3:    nb = NB_PHASE;
            default: nb = NB_AMP;
        endcase

        case (state_q)
            S_IDLE: begin
                if (i_data_valid && i_data[3:0] != 4'd0) begin
                    if (i_data[3:0] <= 4'd4 && {1'b0, i_data[7:4]} < NUM_OSC_L) begin
                        osc_d   = i_data[7:4];
                        id_d    = i_data[2:0];
                        buf_d   = '0;
                        cnt_d   = '0;
                        to_d    = '0;
                        state_d = S_DATA;
`ifdef SYNTH_PARAM_CHECKSUM_EN
                        chk_d   = i_data;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                if (i_data_valid) begin
                    to_d = '0;
`ifdef SYNTH_PARAM_CHECKSUM_EN
                    if (cnt_q == nb) begin
                        state_d = S_IDLE;
                        if (i_data == chk_q) commit = 1'b1;
                        else                 err_d  = 1'b1;
                    end else begin
                        buf_d = {buf_q[23:0], i_data};
                        chk_d = chk_q ^ i_data;
                        cnt_d = cnt_q + 3'd1;
                    end
`else
                    if (cnt_q == nb - 3'd1) begin
                        commit  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        buf_d = {buf_q[23:0], i_data};
                        cnt_d = cnt_q + 3'd1;
                    end
`endif
                end else if (TIMEOUT_CYCLES > 0) begin
                    if (to_q == TO_W'(TO_LAST)) begin
                        state_d = S_IDLE;
                        tmo_d   = 1'b1;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
            end
        endcase

        // Excess high bits of the assembled value are dropped per target width.
        for (int n = 0; n < NUM_OSC; n++) begin
            if (commit && osc_q == 4'(n)) begin
                upd_d[n] = 1'b1;
                case (id_q)
                    3'd1:    wave_d[n*WAVE_W +: WAVE_W]   = commit_val[WAVE_W-1:0];
                    3'd2:    freq_d[n*FREQ_W +: FREQ_W]   = commit_val[FREQ_W-1:0];
                    3'd3:    phase_d[n*PHASE_W +: PHASE_W] = commit_val[PHASE_W-1:0];
                    default: amp_d[n*AMP_W +: AMP_W]      = commit_val[AMP_W-1:0];
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            osc_q   <= '0;
            id_q    <= '0;
            buf_q   <= '0;
            cnt_q   <= '0;
            to_q    <= '0;
            wave_q  <= '0;
            freq_q  <= '0;
            phase_q <= '0;
            amp_q   <= '0;
            upd_q   <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
`ifdef SYNTH_PARAM_CHECKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            osc_q   <= osc_d;
            id_q    <= id_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            wave_q  <= wave_d;
            freq_q  <= freq_d;
            phase_q <= phase_d;
            amp_q   <= amp_d;
            upd_q   <= upd_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
`ifdef SYNTH_PARAM_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    assign unused_ok   = ^{commit_val, buf_q};
    assign o_osc_wave  = wave_q;
    assign o_osc_freq  = freq_q;
    assign o_osc_phase = phase_q;
    assign o_osc_amp   = amp_q;
    assign o_update    = upd_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_cmd_err   = err_q;
    assign o_timeout   = tmo_q;

endmodule

// File: tb/tb_synth_param_decoder.sv
// Bench for synth_param_decoder: directed vector table, hand sequences for
// timeout/reset corners, and random frames checked against a frame-level model.
module tb_synth_param_decoder;

    localparam int NUM_OSC = 2;
    localparam int WAVE_W  = 8;
    localparam int FREQ_W  = 24;
    localparam int PHASE_W = 16;
    localparam int AMP_W   = 16;
    localparam int TMO     = 10;
`ifdef SYNTH_PARAM_CHECKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic                       i_clk = 1'b0;
    logic                       i_rst;
    logic [7:0]                 i_data;
    logic                       i_data_valid;
    logic [NUM_OSC*WAVE_W-1:0]  o_osc_wave;
    logic [NUM_OSC*FREQ_W-1:0]  o_osc_freq;
    logic [NUM_OSC*PHASE_W-1:0] o_osc_phase;
    logic [NUM_OSC*AMP_W-1:0]   o_osc_amp;
    logic [NUM_OSC-1:0]         o_update;
    logic                       o_busy;
    logic                       o_cmd_err;
    logic                       o_timeout;

    synth_param_decoder #(
        .NUM_OSC(NUM_OSC), .WAVE_W(WAVE_W), .FREQ_W(FREQ_W),
        .PHASE_W(PHASE_W), .AMP_W(AMP_W), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_data_valid(i_data_valid),
        .o_osc_wave(o_osc_wave), .o_osc_freq(o_osc_freq), .o_osc_phase(o_osc_phase),
        .o_osc_amp(o_osc_amp), .o_update(o_update), .o_busy(o_busy),
        .o_cmd_err(o_cmd_err), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Frame-level reference: a frame is just the list of bytes received so far.
    logic [7:0]  frame[$];
    int          idle_cnt;
    int          m_osc, m_id;
    logic [31:0] m_wave[NUM_OSC], m_freq[NUM_OSC], m_phase[NUM_OSC], m_amp[NUM_OSC];
    logic [NUM_OSC-1:0] m_upd;
    logic        m_err, m_tmo;

    function automatic int nb_of(int id);
        int w;
        case (id)
            1: w = WAVE_W;
            2: w = FREQ_W;
            3: w = PHASE_W;
            default: w = AMP_W;
        endcase
        return (w + 7) / 8;
    endfunction

    function automatic logic [31:0] trunc(longint unsigned v, int w);
        longint unsigned m;
        m = (64'd1 << w) - 64'd1;
        return 32'(v & m);
    endfunction

    function automatic void model_step(logic r, logic v, logic [7:0] d);
        m_upd = '0; m_err = 1'b0; m_tmo = 1'b0;
        if (r) begin
            for (int n = 0; n < NUM_OSC; n++) begin
                m_wave[n] = 0; m_freq[n] = 0; m_phase[n] = 0; m_amp[n] = 0;
            end
            frame.delete();
            idle_cnt = 0;
        end else if (frame.size() == 0) begin
            if (v && d[3:0] != 0) begin
                if (int'(d[3:0]) > 4 || int'(d[7:4]) >= NUM_OSC) m_err = 1'b1;
                else begin
                    frame.push_back(d);
                    m_osc = int'(d[7:4]);
                    m_id = int'(d[3:0]);
                    idle_cnt = 0;
                end
            end
        end else if (v) begin
            int nb;
            frame.push_back(d);
            idle_cnt = 0;
            nb = nb_of(m_id);
            if (frame.size() == 1 + nb + CHK) begin
                longint unsigned val = 0;
                logic [7:0] x = 8'h00;
                bit ok = 1;
                for (int k = 1; k <= nb; k++) val = (val << 8) | longint'(frame[k]);
                for (int k = 0; k <= nb; k++) x ^= frame[k];
                if (CHK != 0) ok = (x == frame[nb+1]);
                if (ok) begin
                    m_upd[m_osc] = 1'b1;
                    case (m_id)
                        1: m_wave[m_osc]  = trunc(val, WAVE_W);
                        2: m_freq[m_osc]  = trunc(val, FREQ_W);
                        3: m_phase[m_osc] = trunc(val, PHASE_W);
                        default: m_amp[m_osc] = trunc(val, AMP_W);
                    endcase
                end else m_err = 1'b1;
                frame.delete();
            end
        end else begin
            idle_cnt++;
            if (TMO > 0 && idle_cnt == TMO) begin
                m_tmo = 1'b1;
                frame.delete();
            end
        end
    endfunction

    task automatic check_all();
        logic [NUM_OSC*WAVE_W-1:0]  ew;
        logic [NUM_OSC*FREQ_W-1:0]  ef;
        logic [NUM_OSC*PHASE_W-1:0] ep;
        logic [NUM_OSC*AMP_W-1:0]   ea;
        logic eb;
        for (int n = 0; n < NUM_OSC; n++) begin
            ew[n*WAVE_W +: WAVE_W]   = m_wave[n][WAVE_W-1:0];
            ef[n*FREQ_W +: FREQ_W]   = m_freq[n][FREQ_W-1:0];
            ep[n*PHASE_W +: PHASE_W] = m_phase[n][PHASE_W-1:0];
            ea[n*AMP_W +: AMP_W]     = m_amp[n][AMP_W-1:0];
        end
        eb = (frame.size() != 0);
        n_tests++;
        if (o_osc_wave !== ew || o_osc_freq !== ef || o_osc_phase !== ep ||
            o_osc_amp !== ea || o_update !== m_upd || o_cmd_err !== m_err ||
            o_timeout !== m_tmo || o_busy !== eb) begin
            n_fail++;
            $display("FAIL model t=%0t: got wave=%h freq=%h phase=%h amp=%h upd=%b err=%b tmo=%b busy=%b; want wave=%h freq=%h phase=%h amp=%h upd=%b err=%b tmo=%b busy=%b",
                     $time, o_osc_wave, o_osc_freq, o_osc_phase, o_osc_amp, o_update,
                     o_cmd_err, o_timeout, o_busy, ew, ef, ep, ea, m_upd, m_err, m_tmo, eb);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] d);
        i_rst = r; i_data_valid = v; i_data = d;
        @(posedge i_clk);
        model_step(r, v, d);
        #1;
        check_all();
    endtask

    task automatic hand_check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       v;
        logic [7:0] d;
        logic [1:0] upd;
        logic       err;
        logic       tmo;
        logic       busy;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(logic v, logic [7:0] d, logic [1:0] upd, logic err, logic busy);
        vec_t e;
        e.rst = 1'b0; e.v = v; e.d = d; e.upd = upd; e.err = err; e.tmo = 1'b0; e.busy = busy;
        vecs.push_back(e);
    endfunction

    initial begin
        i_rst = 1'b1; i_data_valid = 1'b0; i_data = 8'h00;
        idle_cnt = 0; m_osc = 0; m_id = 0;
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        hand_check("reset_outputs", {28'd0, o_update, o_busy, o_cmd_err, o_timeout}, 32'd0);
        hand_check("reset_freq0", {8'd0, o_osc_freq[23:0]}, 32'd0);

`ifndef SYNTH_PARAM_CHECKSUM_EN
        add(1, 8'h02, 2'b00, 0, 1); add(1, 8'h12, 2'b00, 0, 1);
        add(1, 8'h34, 2'b00, 0, 1); add(1, 8'h56, 2'b01, 0, 0);
        add(0, 8'h00, 2'b00, 0, 0);
        add(1, 8'h11, 2'b00, 0, 1); add(1, 8'h05, 2'b10, 0, 0);
        add(1, 8'h14, 2'b00, 0, 1); add(1, 8'hAB, 2'b00, 0, 1);
        add(1, 8'hCD, 2'b10, 0, 0); add(0, 8'h00, 2'b00, 0, 0);
        add(1, 8'h25, 2'b00, 1, 0); add(0, 8'h00, 2'b00, 0, 0);
        add(1, 8'h07, 2'b00, 1, 0); add(0, 8'h00, 2'b00, 0, 0);
        add(1, 8'h00, 2'b00, 0, 0); add(0, 8'h00, 2'b00, 0, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].v, vecs[i].d);
            n_tests++;
            if ({o_update, o_cmd_err, o_timeout, o_busy} !==
                {vecs[i].upd, vecs[i].err, vecs[i].tmo, vecs[i].busy}) begin
                n_fail++;
                $display("FAIL vec%0d: got upd/err/tmo/busy=%b want %b", i,
                         {o_update, o_cmd_err, o_timeout, o_busy},
                         {vecs[i].upd, vecs[i].err, vecs[i].tmo, vecs[i].busy});
            end
        end
        hand_check("freq0_123456", {8'd0, o_osc_freq[23:0]}, 32'h123456);
        hand_check("wave1_05", {24'd0, o_osc_wave[15:8]}, 32'h05);
        hand_check("amp1_abcd", {16'd0, o_osc_amp[31:16]}, 32'hABCD);
        hand_check("osc0_wave_amp_unchanged", {o_osc_wave[7:0], 8'd0, o_osc_amp[15:0]}, 32'd0);

        // Timeout: ten idle cycles abort the frame.
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h03);
        step(1'b0, 1'b1, 8'h7F);
        for (int i = 0; i < TMO - 1; i++) step(1'b0, 1'b0, 8'h00);
        hand_check("tmo_not_early", {30'd0, o_timeout, o_busy}, 32'd1);
        step(1'b0, 1'b0, 8'h00);
        hand_check("tmo_pulse", {30'd0, o_timeout, o_busy}, 32'd2);
        step(1'b0, 1'b0, 8'h00);
        hand_check("tmo_one_cycle", {31'd0, o_timeout}, 32'd0);
        hand_check("tmo_phase0", {16'd0, o_osc_phase[15:0]}, 32'd0);

        // Byte on the expiry cycle is accepted.
        step(1'b0, 1'b1, 8'h03);
        step(1'b0, 1'b1, 8'h7F);
        for (int i = 0; i < TMO - 1; i++) step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        hand_check("expiry_accept_upd", {29'd0, o_update, o_timeout}, 32'b010);
        hand_check("expiry_phase0", {16'd0, o_osc_phase[15:0]}, 32'h7F00);

        // Reset mid-frame drops partial data.
        step(1'b0, 1'b1, 8'h02);
        step(1'b0, 1'b1, 8'hAA);
        step(1'b1, 1'b0, 8'h00);
        hand_check("rst_midframe_busy", {31'd0, o_busy}, 32'd0);
        step(1'b0, 1'b1, 8'h02);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h01);
        hand_check("freq0_after_rst", {8'd0, o_osc_freq[23:0]}, 32'h000001);
`else
        step(1'b0, 1'b1, 8'h01);
        step(1'b0, 1'b1, 8'h03);
        step(1'b0, 1'b1, 8'h02);
        hand_check("chk_ok_wave0", {24'd0, o_osc_wave[7:0]}, 32'h03);
        hand_check("chk_ok_upd", {30'd0, o_update}, 32'd1);
        step(1'b0, 1'b1, 8'h01);
        step(1'b0, 1'b1, 8'h03);
        step(1'b0, 1'b1, 8'hFF);
        hand_check("chk_bad_err", {30'd0, o_update, o_cmd_err}, 32'd1);
        hand_check("chk_bad_wave0", {24'd0, o_osc_wave[7:0]}, 32'h03);
`endif

        // Random frames with gaps, illegal commands and occasional resets.
        for (int f = 0; f < 300; f++) begin
            logic [7:0] cmd, x;
            int nb;
            if ($urandom_range(0, 39) == 0) step(1'b1, 1'b0, 8'h00);
            if ($urandom_range(0, 3) == 0) cmd = 8'($urandom_range(0, 255));
            else cmd = {4'($urandom_range(0, NUM_OSC - 1)), 4'($urandom_range(1, 4))};
            nb = nb_of(int'(cmd[3:0]));
            x = cmd;
            step(1'b0, 1'b1, cmd);
            for (int b = 0; b < nb + CHK; b++) begin
                logic [7:0] d;
                int gap;
                gap = ($urandom_range(0, 11) == 0) ? $urandom_range(0, TMO + 3) : $urandom_range(0, 1);
                for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 8'h00);
                d = 8'($urandom_range(0, 255));
                if (b == nb) d = ($urandom_range(0, 3) == 0) ? d : x;
                x ^= d;
                step(1'b0, 1'b1, d);
            end
            if ($urandom_range(0, 1) == 0) step(1'b0, 1'b0, 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/synth_param_decoder.md
Name: synth_param_decoder

Overview:
Clocked, parametrised command decoder for the synth control path. It receives a byte stream with a per-byte valid strobe and decodes command bytes that address one parameter of one of NUM_OSC oscillators. It assembles the multi-byte value that follows and commits it to that oscillator's parameter register. It adds an inter-byte timeout, error reporting and per-oscillator update strobes, and drives the oscillator bank directly.

Parameters:
NUM_OSC, 2, number of oscillators; legal range 1..16
WAVE_W, 8, waveform select width (1..32)
FREQ_W, 24, frequency word width (1..32)
PHASE_W, 16, phase offset width (1..32)
AMP_W, 16, amplitude width (1..32)
TIMEOUT_CYCLES, 1000, clock cycles allowed between data bytes; 0 disables the timeout

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous reset, active-high
i_data  in  8  command/data byte
i_data_valid  in  1  byte strobe; one byte is accepted per cycle while high
o_osc_wave  out  NUM_OSC*WAVE_W  packed; oscillator n is at [n*WAVE_W +: WAVE_W]
o_osc_freq  out  NUM_OSC*FREQ_W  packed, same layout
o_osc_phase  out  NUM_OSC*PHASE_W  packed, same layout
o_osc_amp  out  NUM_OSC*AMP_W  packed, same layout
o_update  out  NUM_OSC  one-cycle pulse; bit n marks a parameter commit to oscillator n
o_busy  out  1  high while a frame is in progress (state is not IDLE)
o_cmd_err  out  1  one-cycle pulse on an illegal command byte (or checksum failure)
o_timeout  out  1  one-cycle pulse when a frame is aborted by timeout

Behaviour:
- Reset: i_clk and i_rst are the only clock and reset. Synchronous, active-high reset. All o_osc_* registers, o_update, o_busy, o_cmd_err, o_timeout, the byte counter and the timeout counter clear to 0. State returns to IDLE. Reset mid-frame discards the partial frame with no commit.
- Command byte: [7:4] = oscillator index, [3:0] = parameter ID.
  - ID 1 = wave, 2 = freq, 3 = phase, 4 = amp.
  - ID 0 = NOP: ignored, no error.
- Byte count per parameter: NB = ceil(W/8) for that parameter's width (defaults: wave 1, freq 3, phase 2, amp 2).
- States:
  - IDLE: a valid byte is decoded as a command. If the command is legal, latch the target, clear the assembly buffer, go to DATA.
  - If index >= NUM_OSC, or ID is 5..15: o_cmd_err pulses on the next cycle and the state stays IDLE.
  - DATA: each valid byte shifts into the assembly buffer, MSB-first (buffer <= {buffer, byte}) and increments the byte counter.
  - On the edge that accepts byte NB, the target register loads the low W bits of the assembled value; excess high bits are discarded. The matching o_update bit is high for the following cycle only. The state returns to IDLE on that same edge.
  - Commit latency: the new value is visible on the cycle after the last byte is accepted.
- Back-to-back frames: a valid byte in the cycle after a commit is decoded as a new command. Commands need no idle gap.
- Timeout (TIMEOUT_CYCLES > 0):
  - In DATA, the counter increments on each cycle with i_data_valid low. It clears on any accepted byte.
  - When it reaches TIMEOUT_CYCLES: abort to IDLE, pulse o_timeout, no commit.
  - A valid byte on the expiry cycle is accepted and prevents the timeout.
- Registers not being written hold their values. Only one oscillator parameter changes per frame.
- Outputs are registered. o_busy = (state != IDLE).

Optional Feature:
Macro SYNTH_PARAM_CHECKSUM_EN.
- Defined: each frame carries one extra trailing byte after the NB data bytes. That byte must equal the XOR of the command byte and all data bytes.
  - Match: commit exactly as above, on the edge accepting the checksum byte.
  - Mismatch: no commit, o_cmd_err pulses, state returns to IDLE.
  - The timeout also applies while waiting for the checksum byte.
- Undefined: no checksum byte. The frame ends at byte NB and there is no checksum logic.

Test Plan:
1. Reset, then stream 0x02,0x12,0x34,0x56 with valid high on consecutive cycles -> o_osc_freq[23:0] = 0x123456 one cycle after the last byte; o_update = 2'b01 for exactly one cycle; all other outputs remain 0.
2. Stream 0x11,0x05 then 0x14,0xAB,0xCD back-to-back -> osc1 wave = 0x05, then osc1 amp = 0xABCD; o_update = 2'b10 pulses twice; osc0 registers are unchanged.
3. Send 0x25 (index 2 with NUM_OSC = 2) and, separately, 0x07 -> o_cmd_err pulses once for each; o_busy stays 0; no register changes.
4. With TIMEOUT_CYCLES = 10, send 0x03,0x7F then hold valid low for 10 cycles -> o_timeout pulses, o_busy falls, phase0 stays 0. Repeat with the next byte arriving exactly on the expiry cycle -> the byte is accepted and phase0 = 0x7F00.
5. Assert i_rst after 0x02,0xAA -> the frame is dropped. Then send 0x02,0x00,0x00,0x01 -> freq0 = 0x000001 (the old 0xAA must not appear).
6. (SYNTH_PARAM_CHECKSUM_EN) Send 0x01,0x03,0x02 -> wave0 = 0x03, o_update pulses. Send 0x01,0x03,0xFF -> o_cmd_err pulses and wave0 is unchanged.
